// File: rtl/xpb_table_lut_if.sv
// Bundle of load, lookup and status signals for the xpb_table_lut lookup table.
// master drives loads/lookups; slave is the table itself.
interface xpb_table_lut_if #(
  parameter int IDX_BITS  = 5,
  parameter int WORD_BITS = 1024,
  parameter int SEG_BITS  = 64,
  parameter int NUM_CH    = 2
);
  localparam int NSEG = WORD_BITS / SEG_BITS;
  localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;

  logic                        clear;
  logic                        ld_valid;
  logic                        ld_ready;
  logic [IDX_BITS-1:0]         ld_idx;
  logic [SEGW-1:0]             ld_seg;
  logic [SEG_BITS-1:0]         ld_data;
  logic                        ld_err;
  logic [NUM_CH-1:0]           lk_valid;
  logic [NUM_CH*IDX_BITS-1:0]  lk_idx;
  logic [NUM_CH-1:0]           out_valid;
  logic [NUM_CH*WORD_BITS-1:0] out_data;
  logic [NUM_CH-1:0]           out_miss;
  logic                        table_full;

  modport master (
    output clear, ld_valid, ld_idx, ld_seg, ld_data, lk_valid, lk_idx,
    input  ld_ready, ld_err, out_valid, out_data, out_miss, table_full
  );

  modport slave (
    input  clear, ld_valid, ld_idx, ld_seg, ld_data, lk_valid, lk_idx,
    output ld_ready, ld_err, out_valid, out_data, out_miss, table_full
  );
endinterface

// File: rtl/xpb_table_lut.sv
// Wide-word lookup table: entries are loaded segment by segment through a small
// FSM and read by NUM_CH independent two-stage lookup pipelines.
module xpb_table_lut #(
  parameter int IDX_BITS  = 5,
  parameter int WORD_BITS = 1024,
  parameter int SEG_BITS  = 64,
  parameter int NUM_CH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  xpb_table_lut_if.slave   bus
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam int NSEG  = WORD_BITS / SEG_BITS;
  localparam int SEGW  = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SEGW-1:0] LAST_SEG = SEGW'(NSEG - 1);
  localparam logic [SEGW:0]   SEG_ONE  = (SEGW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT
  } load_state_e;

  load_state_e                 state_q, state_d;
  logic [IDX_BITS-1:0]         lidx_q, lidx_d;
  logic [SEGW-1:0]             lseg_q, lseg_d;
  logic [WORD_BITS-1:0]        staging_q, staging_d;
  logic                        ld_err_q, ld_err_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic                        table_full_q, table_full_d;
  logic [WORD_BITS-1:0]        table_q [DEPTH];
  logic                        wr_en;
  logic                        accept;
  logic                        seg_ok;

  logic [NUM_CH-1:0]           s0_valid_q, s0_valid_d;
  logic [NUM_CH-1:0]           s1_valid_q, s1_valid_d;
  logic [NUM_CH*IDX_BITS-1:0]  s0_idx_q, s0_idx_d;
  logic [NUM_CH*IDX_BITS-1:0]  s1_idx_q, s1_idx_d;
  logic [NUM_CH-1:0]           out_valid_q, out_valid_d;
  logic [NUM_CH-1:0]           out_miss_q, out_miss_d;
  logic [NUM_CH*WORD_BITS-1:0] out_data_q, out_data_d;
  logic [IDX_BITS-1:0]         rd_idx;

  assign bus.ld_ready   = (state_q != COMMIT) && !reset;
  assign bus.ld_err     = ld_err_q;
  assign bus.table_full = table_full_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_miss   = out_miss_q;

  assign accept = bus.ld_valid && bus.ld_ready;
  assign seg_ok = (bus.ld_idx == lidx_q) &&
                  ({1'b0, bus.ld_seg} == ({1'b0, lseg_q} + SEG_ONE));

  // Load sequencing; clear overrides everything including a pending commit.
  always_comb begin
    state_d   = state_q;
    lidx_d    = lidx_q;
    lseg_d    = lseg_q;
    staging_d = staging_q;
    ld_err_d  = 1'b0;
    valid_d   = valid_q;
    wr_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.ld_seg == '0) begin
            lidx_d                  = bus.ld_idx;
            lseg_d                  = '0;
            staging_d[SEG_BITS-1:0] = bus.ld_data;
            state_d                 = (NSEG == 1) ? COMMIT : FILL;
          end else begin
            ld_err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (seg_ok) begin
            staging_d[int'(bus.ld_seg)*SEG_BITS +: SEG_BITS] = bus.ld_data;
            lseg_d = bus.ld_seg;
            if (bus.ld_seg == LAST_SEG) begin
              state_d = COMMIT;
            end
          end else begin
            ld_err_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      COMMIT: begin
        wr_en = (lidx_q != '0);
        if (wr_en) begin
          valid_d[lidx_q] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.clear) begin
      valid_d  = '0;
      state_d  = IDLE;
      ld_err_d = 1'b0;
      wr_en    = 1'b0;
    end

    valid_d[0]   = 1'b0;
    table_full_d = &valid_q[DEPTH-1:1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lidx_q       <= '0;
      lseg_q       <= '0;
      staging_q    <= '0;
      ld_err_q     <= 1'b0;
      valid_q      <= '0;
      table_full_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lidx_q       <= lidx_d;
      lseg_q       <= lseg_d;
      staging_q    <= staging_d;
      ld_err_q     <= ld_err_d;
      valid_q      <= valid_d;
      table_full_q <= table_full_d;
    end
  end

  // Payload storage is not reset; the valid bits alone decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      table_q[lidx_q] <= staging_q;
    end
  end

  always_comb begin
    s0_valid_d = bus.lk_valid;
    s0_idx_d   = bus.lk_idx;
    s1_valid_d = s0_valid_q;
    s1_idx_d   = s0_idx_q;
  end

  // The table is read from the second stage so a commit closing one edge
  // after the request is still seen by it.
  always_comb begin
    out_valid_d = s1_valid_q;
    out_data_d  = '0;
    out_miss_d  = '0;
    rd_idx      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_idx = s1_idx_q[c*IDX_BITS +: IDX_BITS];
      if (s1_valid_q[c] && (rd_idx != '0)) begin
        if (valid_q[rd_idx]) begin
          out_data_d[c*WORD_BITS +: WORD_BITS] = table_q[rd_idx];
        end else begin
          out_miss_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_valid_q  <= '0;
      s0_idx_q    <= '0;
      s1_valid_q  <= '0;
      s1_idx_q    <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_miss_q  <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_idx_q    <= s0_idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_idx_q    <= s1_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_miss_q  <= out_miss_d;
    end
  end

endmodule

// File: tb/tb_xpb_table_lut.sv
// Scoreboard bench for xpb_table_lut: lookups push expected results from a
// reference table model, a negedge monitor pops and compares them.
module tb_xpb_table_lut;

  localparam int IDX_BITS  = 5;
  localparam int WORD_BITS = 1024;
  localparam int SEG_BITS  = 64;
  localparam int NUM_CH    = 2;
  localparam int NSEG      = WORD_BITS / SEG_BITS;
  localparam int DEPTH     = 2 ** IDX_BITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  xpb_table_lut_if #(.IDX_BITS(IDX_BITS), .WORD_BITS(WORD_BITS),
                     .SEG_BITS(SEG_BITS), .NUM_CH(NUM_CH)) bus ();

  xpb_table_lut #(.IDX_BITS(IDX_BITS), .WORD_BITS(WORD_BITS),
                  .SEG_BITS(SEG_BITS), .NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [WORD_BITS-1:0] data;
    logic                 miss;
    int                   due;
  } exp_t;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  exp_t sb [NUM_CH][$];
  logic [WORD_BITS-1:0] mdl_data [DEPTH];
  logic                 mdl_valid [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [WORD_BITS-1:0] got;
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        got = bus.out_data[c*WORD_BITS +: WORD_BITS];
        if (bus.out_valid[c]) begin
          checks++;
          if (sb[c].size() == 0) begin
            $display("[TB] FAIL ch%0d unexpected result: got out_valid=1 data=%h, required no result", c, got[127:0]);
          end else begin
            e = sb[c].pop_front();
            if (got !== e.data || bus.out_miss[c] !== e.miss || cyc !== e.due)
              $display("[TB] FAIL ch%0d result: got data=%h miss=%b cyc=%0d, required data=%h miss=%b cyc=%0d",
                       c, got[127:0], bus.out_miss[c], cyc, e.data[127:0], e.miss, e.due);
            else
              passes++;
          end
        end else begin
          if (sb[c].size() > 0 && sb[c][0].due <= cyc) begin
            e = sb[c].pop_front();
            checks++;
            $display("[TB] FAIL ch%0d missing result: got out_valid=0 at cyc=%0d, required result due cyc=%0d", c, cyc, e.due);
          end
          checks++;
          if (got !== '0 || bus.out_miss[c] !== 1'b0)
            $display("[TB] FAIL ch%0d idle outputs: got data=%h miss=%b, required 0/0", c, got[127:0], bus.out_miss[c]);
          else
            passes++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (5) tick();
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mdl_valid[i] = 1'b0;
  endtask

  function automatic logic [WORD_BITS-1:0] make_word(input int idx, input int salt);
    logic [WORD_BITS-1:0] w;
    for (int s = 0; s < NSEG; s++)
      w[s*SEG_BITS +: SEG_BITS] = {8'(idx), 8'(s), 16'(salt), 32'hC0DE_0000 ^ 32'(idx * 97 + s * 13)};
    return w;
  endfunction

  task automatic issue_exp(input int c, input int idx, input logic [WORD_BITS-1:0] d, input logic m);
    exp_t e;
    bus.lk_valid[c] = 1'b1;
    bus.lk_idx[c*IDX_BITS +: IDX_BITS] = IDX_BITS'(idx);
    e.data = d;
    e.miss = m;
    e.due  = cyc + 3;
    sb[c].push_back(e);
  endtask

  task automatic issue(input int c, input int idx);
    logic hit;
    hit = (idx != 0) && mdl_valid[idx];
    issue_exp(c, idx, hit ? mdl_data[idx] : '0, (idx != 0) && !hit);
  endtask

  task automatic send_seg(input int idx, input int seg, input logic [SEG_BITS-1:0] d);
    int n = 0;
    bus.ld_valid = 1'b1;
    bus.ld_idx   = IDX_BITS'(idx);
    bus.ld_seg   = 4'(seg);
    bus.ld_data  = d;
    while (bus.ld_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (n == 8) begin
      checks++;
      $display("[TB] FAIL ld_ready wait: got ld_ready=%b after 8 cycles, required 1", bus.ld_ready);
    end
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic load_entry(input int idx, input logic [WORD_BITS-1:0] w);
    for (int s = 0; s < NSEG; s++) send_seg(idx, s, w[s*SEG_BITS +: SEG_BITS]);
    if (idx != 0) begin
      mdl_data[idx]  = w;
      mdl_valid[idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ld_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ld_ready !== 1'b0) $display("[TB] FAIL reset ld_ready: got %b, required 0", bus.ld_ready);
    else passes++;
    bus.ld_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== '0 || bus.out_data !== '0 || bus.out_miss !== '0)
      $display("[TB] FAIL reset outputs: got valid=%b miss=%b data_lo=%h, required all 0", bus.out_valid, bus.out_miss, bus.out_data[63:0]);
    else passes++;
    checks++;
    if (bus.ld_err !== 1'b0 || bus.table_full !== 1'b0)
      $display("[TB] FAIL reset status: got ld_err=%b table_full=%b, required 0/0", bus.ld_err, bus.table_full);
    else passes++;
    checks++;
    if (bus.ld_ready !== 1'b1) $display("[TB] FAIL idle ld_ready: got %b, required 1", bus.ld_ready);
    else passes++;
    tick();
  endtask

  task automatic test_empty_lookup();
    issue(0, 7);
    issue(1, 7);
    tick();
    issue(0, 0);
    issue(1, 0);
    tick();
    bus.lk_valid = '0;
    drain();
  endtask

  task automatic test_load_basic();
    logic [WORD_BITS-1:0] w;
    for (int s = 0; s < NSEG; s++)
      w[s*SEG_BITS +: SEG_BITS] = 64'h1111_1111_1111_1111 * 64'(s + 1);
    load_entry(1, w);
    issue(0, 1);
    tick();
    bus.lk_valid = '0;
    issue(1, 1);
    tick();
    bus.lk_valid = '0;
    drain();
  endtask

  task automatic test_bad_sequence();
    send_seg(3, 0, 64'hA);
    send_seg(3, 1, 64'hB);
    checks++;
    if (bus.ld_err !== 1'b0) $display("[TB] FAIL ld_err good seg: got %b, required 0", bus.ld_err);
    else passes++;
    send_seg(3, 3, 64'hC);
    checks++;
    if (bus.ld_err !== 1'b1) $display("[TB] FAIL ld_err skipped seg: got %b, required 1", bus.ld_err);
    else passes++;
    tick();
    checks++;
    if (bus.ld_err !== 1'b0) $display("[TB] FAIL ld_err pulse width: got %b, required 0", bus.ld_err);
    else passes++;
    issue(0, 3);
    tick();
    bus.lk_valid = '0;
    send_seg(4, 2, 64'hD);
    checks++;
    if (bus.ld_err !== 1'b1) $display("[TB] FAIL ld_err idle nonzero seg: got %b, required 1", bus.ld_err);
    else passes++;
    send_seg(4, 0, 64'hE);
    send_seg(6, 1, 64'hF);
    checks++;
    if (bus.ld_err !== 1'b1) $display("[TB] FAIL ld_err idx change: got %b, required 1", bus.ld_err);
    else passes++;
    load_entry(3, make_word(3, 1));
    issue(0, 3);
    issue(1, 3);
    tick();
    bus.lk_valid = '0;
    drain();
  endtask

  task automatic test_commit_race();
    logic [WORD_BITS-1:0] wa, wb;
    wa = make_word(5, 2);
    wb = make_word(5, 3);
    for (int s = 0; s < NSEG - 2; s++) send_seg(5, s, wa[s*SEG_BITS +: SEG_BITS]);
    bus.ld_valid = 1'b1;
    bus.ld_seg   = 4'(NSEG - 2);
    bus.ld_data  = wa[(NSEG-2)*SEG_BITS +: SEG_BITS];
    issue_exp(0, 5, '0, 1'b1);
    tick();
    bus.lk_valid = '0;
    bus.ld_seg   = 4'(NSEG - 1);
    bus.ld_data  = wa[(NSEG-1)*SEG_BITS +: SEG_BITS];
    tick();
    bus.ld_valid = 1'b0;
    mdl_data[5] = wa;
    mdl_valid[5] = 1'b1;
    drain();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_clear();
    for (int s = 0; s < NSEG - 1; s++) send_seg(5, s, wb[s*SEG_BITS +: SEG_BITS]);
    bus.ld_valid = 1'b1;
    bus.ld_seg   = 4'(NSEG - 1);
    bus.ld_data  = wb[(NSEG-1)*SEG_BITS +: SEG_BITS];
    issue_exp(0, 5, wb, 1'b0);
    issue(1, 1);
    tick();
    bus.lk_valid = '0;
    bus.ld_valid = 1'b0;
    mdl_data[5] = wb;
    mdl_valid[5] = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    load_entry(2, make_word(2, 6));
    load_entry(10, make_word(10, 6));
    for (int i = 0; i < 12; i++) begin
      issue(0, $urandom_range(0, 15));
      issue(1, $urandom_range(0, 15));
      tick();
    end
    bus.lk_valid = '0;
    drain();
  endtask

  task automatic test_full_and_clear();
    logic [WORD_BITS-1:0] w;
    for (int i = 1; i < DEPTH - 1; i++) load_entry(i, make_word(i, 4));
    tick();
    tick();
    checks++;
    if (bus.table_full !== 1'b0) $display("[TB] FAIL table_full 30 entries: got %b, required 0", bus.table_full);
    else passes++;
    load_entry(DEPTH - 1, make_word(DEPTH - 1, 4));
    tick();
    checks++;
    if (bus.table_full !== 1'b0) $display("[TB] FAIL table_full at commit edge: got %b, required 0", bus.table_full);
    else passes++;
    tick();
    checks++;
    if (bus.table_full !== 1'b1) $display("[TB] FAIL table_full after commit: got %b, required 1", bus.table_full);
    else passes++;
    // Reload entry 1 while looking it up: old contents stay visible until commit.
    w = make_word(1, 5);
    for (int s = 0; s < NSEG - 1; s++) begin
      issue(1, 1);
      send_seg(1, s, w[s*SEG_BITS +: SEG_BITS]);
      bus.lk_valid = '0;
    end
    send_seg(1, NSEG - 1, w[(NSEG-1)*SEG_BITS +: SEG_BITS]);
    mdl_data[1] = w;
    issue(0, 1);
    issue(1, 17);
    tick();
    bus.lk_valid = '0;
    drain();
    send_seg(2, 0, 64'h1);
    send_seg(2, 1, 64'h2);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_clear();
    checks++;
    if (bus.ld_err !== 1'b0 || bus.table_full !== 1'b1)
      $display("[TB] FAIL clear edge status: got ld_err=%b table_full=%b, required 0/1", bus.ld_err, bus.table_full);
    else passes++;
    tick();
    checks++;
    if (bus.table_full !== 1'b0) $display("[TB] FAIL table_full after clear: got %b, required 0", bus.table_full);
    else passes++;
    for (int i = 1; i < DEPTH; i++) begin
      issue(0, i);
      issue(1, DEPTH - i);
      tick();
    end
    bus.lk_valid = '0;
    load_entry(2, make_word(2, 7));
    issue(0, 2);
    tick();
    bus.lk_valid = '0;
    drain();
  endtask

  task automatic test_reset_mid_load();
    logic [WORD_BITS-1:0] w;
    w = make_word(9, 8);
    for (int s = 0; s < 8; s++) send_seg(9, s, w[s*SEG_BITS +: SEG_BITS]);
    bus.ld_valid = 1'b1;
    bus.ld_idx   = IDX_BITS'(9);
    bus.ld_seg   = 4'(8);
    bus.ld_data  = w[8*SEG_BITS +: SEG_BITS];
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ld_ready !== 1'b0) $display("[TB] FAIL ld_ready under reset: got %b, required 0", bus.ld_ready);
    else passes++;
    tick();
    tick();
    checks++;
    if (bus.ld_ready !== 1'b0 || bus.table_full !== 1'b0 || bus.ld_err !== 1'b0)
      $display("[TB] FAIL held reset: got ld_ready=%b table_full=%b ld_err=%b, required 0/0/0", bus.ld_ready, bus.table_full, bus.ld_err);
    else passes++;
    bus.ld_valid = 1'b0;
    reset = 1'b0;
    model_clear();
    issue(0, 9);
    issue(1, 2);
    tick();
    bus.lk_valid = '0;
    drain();
    load_entry(9, w);
    issue(0, 9);
    tick();
    bus.lk_valid = '0;
    drain();
  endtask

  initial begin
    bus.clear    = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_idx   = '0;
    bus.ld_seg   = '0;
    bus.ld_data  = '0;
    bus.lk_valid = '0;
    bus.lk_idx   = '0;
    model_clear();
    test_reset();
    test_empty_lookup();
    test_load_basic();
    test_bad_sequence();
    test_commit_race();
    test_back_to_back();
    test_full_and_clear();
    test_reset_mid_load();
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if (sb[c].size() != 0) $display("[TB] FAIL ch%0d leftover: got %0d pending results, required 0", c, sb[c].size());
      else passes++;
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by 500000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
